// File: rtl/booth_prod_accum_if.sv
// Handshake bundle between the Booth multiplier, the accumulator and its consumer.
// slave: accumulator side; master: producer/consumer side (cfg, product in, sum out).
interface booth_prod_accum_if #(
  parameter int N     = 8,
  parameter int CNT_W = 8,
  parameter int ACC_W = 2*N+CNT_W
);
  logic [CNT_W-1:0] cfg_len;
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W:0]   out_count;
  logic             out_ovf;

  modport slave (
    input  cfg_len, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport master (
    output cfg_len, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/booth_prod_accum.sv
// Accumulates bursts of cfg_len Booth products into one wide sum (MAC accumulate half).
// Ports: clk, rst (async high), bus (slave: cfg/in/out handshakes), busy.
// Option: define BOOTH_ACC_SAT_EN for a saturating add with sticky out_ovf.
module booth_prod_accum #(
  parameter int N     = 8,
  parameter int CNT_W = 8,
  parameter int ACC_W = 2*N+CNT_W
) (
  input  logic clk,
  input  logic rst,
  booth_prod_accum_if.slave bus,
  output logic busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [CNT_W:0] ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] FULL = {1'b1, {CNT_W{1'b0}}};

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] nxt;
  logic [CNT_W:0]   cnt;
  logic [CNT_W:0]   len;
  logic [CNT_W:0]   eff_len;
  logic [CNT_W:0]   cnt_inc;
  logic             take;

  assign bus.in_ready = ~rst & (state != S_HOLD);
  assign take         = bus.in_valid & bus.in_ready;
  assign ext          = ACC_W'(bus.in_prod);
  assign cnt_inc      = cnt + ONE;
  assign eff_len      = (bus.cfg_len == '0) ? FULL
                                            : {1'b0, bus.cfg_len};

`ifdef BOOTH_ACC_SAT_EN
  logic [ACC_W:0] sum;
  logic           ovf;
  logic           nxt_ovf;

  assign sum     = {1'b0, acc} + {1'b0, ext};
  assign nxt_ovf = ovf | sum[ACC_W];
  // once clamped, stay at all-ones for the rest of the burst
  assign nxt     = nxt_ovf ? '1 : sum[ACC_W-1:0];
  assign bus.out_ovf = ovf & (state == S_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == S_HOLD && bus.out_ready) begin
      ovf <= 1'b0;
    end else if (state == S_ACCUM && take) begin
      ovf <= nxt_ovf;
    end
  end
`else
  assign nxt         = acc + ext;
  assign bus.out_ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      len   <= '0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (take) begin
            len   <= eff_len;
            acc   <= ext;
            cnt   <= ONE;
            state <= (eff_len == ONE) ? S_HOLD
                                      : S_ACCUM;
          end
        end
        (state == S_ACCUM): begin
          if (take) begin
            acc <= nxt;
            cnt <= cnt_inc;
            if (cnt_inc == len) state <= S_HOLD;
          end
        end
        (state == S_HOLD): begin
          if (bus.out_ready) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid = (state == S_HOLD);
  assign bus.out_sum   = acc;
  assign bus.out_count = cnt;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_booth_prod_accum.sv
// Directed bench for booth_prod_accum (N=8, CNT_W=4, ACC_W=20 and 17).
// Honours BOOTH_ACC_SAT_EN for the overflow expectations.
module tb_booth_prod_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy_a;
  logic busy_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  booth_prod_accum_if #(.N(8), .CNT_W(4), .ACC_W(20)) a ();
  booth_prod_accum_if #(.N(8), .CNT_W(4), .ACC_W(17)) b ();

  booth_prod_accum #(.N(8), .CNT_W(4), .ACC_W(20)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (a),
    .busy (busy_a)
  );

  booth_prod_accum #(.N(8), .CNT_W(4), .ACC_W(17)) u_sat (
    .clk  (clk),
    .rst  (rst),
    .bus  (b),
    .busy (busy_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a.cfg_len = '0; a.in_valid = 0; a.in_prod = '0; a.out_ready = 0;
    b.cfg_len = '0; b.in_valid = 0; b.in_prod = '0; b.out_ready = 0;

    // 1: reset
    #1;
    chk("rst_in_ready", a.in_ready, 0);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_out_sum", a.out_sum, 0);
    chk("rst_out_count", a.out_count, 0);
    chk("rst_out_ovf", a.out_ovf, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_b_in_ready", b.in_ready, 0);
    tick();
    chk("rst_hold_in_ready", a.in_ready, 0);
    rst = 0;
    #1;
    chk("rel_in_ready", a.in_ready, 1);

    // 2: three-beat burst
    a.cfg_len = 4'd3; a.in_valid = 1; a.in_prod = 16'd65025;
    tick();
    chk("s2_busy", busy_a, 1);
    a.in_prod = 16'd600;
    tick();
    chk("s2_mid_valid", a.out_valid, 0);
    a.in_prod = 16'd1;
    tick();
    chk("s2_valid", a.out_valid, 1);
    chk("s2_sum", a.out_sum, 65626);
    chk("s2_count", a.out_count, 3);
    chk("s2_in_ready", a.in_ready, 0);

    // 3: backpressure with a pending beat
    a.in_prod = 16'd7; a.out_ready = 0; a.cfg_len = 4'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s3_hold_valid", a.out_valid, 1);
      chk("s3_hold_sum", a.out_sum, 65626);
    end
    a.out_ready = 1;
    tick();
    chk("s3_drop_valid", a.out_valid, 0);
    chk("s3_idle_ready", a.in_ready, 1);
    a.out_ready = 0;
    tick();
    chk("s3_next_valid", a.out_valid, 1);
    chk("s3_next_sum", a.out_sum, 7);
    chk("s3_next_count", a.out_count, 1);
    a.in_valid = 0; a.out_ready = 1;
    tick();
    chk("s3_done", a.out_valid, 0);
    a.out_ready = 0;

    // 4: cfg_len=0 -> 16 beats, gappy input, cfg_len change mid-burst
    a.cfg_len = 4'd0; a.in_prod = 16'd65025;
    for (int i = 0; i < 32; i++) begin
      a.in_valid = (i % 2 == 0);
      if (i == 3) a.cfg_len = 4'd5;
      tick();
      if (i == 20) chk("s4_mid_valid", a.out_valid, 0);
    end
    a.in_valid = 0;
    chk("s4_valid", a.out_valid, 1);
    chk("s4_sum", a.out_sum, 1040400);
    chk("s4_count", a.out_count, 16);
    chk("s4_ovf", a.out_ovf, 0);
    a.out_ready = 1;
    tick();
    a.out_ready = 0;

    // 5: reset mid-burst
    a.cfg_len = 4'd2; a.in_valid = 1; a.in_prod = 16'd500;
    tick();
    a.in_valid = 0;
    rst = 1;
    #1;
    chk("s5_rst_ready", a.in_ready, 0);
    chk("s5_rst_busy", busy_a, 0);
    tick();
    rst = 0;
    #1;
    chk("s5_no_valid", a.out_valid, 0);
    a.cfg_len = 4'd1; a.in_valid = 1; a.in_prod = 16'd9;
    tick();
    a.in_valid = 0;
    chk("s5_valid", a.out_valid, 1);
    chk("s5_sum", a.out_sum, 9);
    chk("s5_count", a.out_count, 1);

    // 6: narrow accumulator overflow
    b.cfg_len = 4'd3; b.in_valid = 1; b.in_prod = 16'd65025;
    repeat (3) tick();
    b.in_valid = 0;
    chk("s6_valid", b.out_valid, 1);
`ifdef BOOTH_ACC_SAT_EN
    chk("s6_sum", b.out_sum, 131071);
    chk("s6_ovf", b.out_ovf, 1);
`else
    chk("s6_sum", b.out_sum, 64003);
    chk("s6_ovf", b.out_ovf, 0);
`endif
    b.out_ready = 1;
    tick();
    chk("s6_idle_ovf", b.out_ovf, 0);
    chk("s6_idle_sum", b.out_sum, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
